if_fetch_buffer: RTL

- Parametrised next-generation IF stage for the LoongArch pipeline.
- Replaces the single-register fetch with a decoupled fetch engine on an `inst_req`/`addr_ok`/`data_ok` SRAM-like bus.
- Supports up to MAX_OUTSTANDING in-flight fetches and an IBUF_DEPTH instruction buffer in front of ID.
- Handles exception, ertn and branch redirects, and discards stale responses after a flush.

---
 rtl/if_fetch_buffer.sv | 101 ++++++++++
 1 files changed

// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer: decoupled IF stage with in-flight fetch tracking, flush cancellation and an instruction buffer toward ID
module if_fetch_buffer #(
   parameter logic [31:0] RESET_PC        = 32'h1c000000,
   parameter int          IBUF_DEPTH      = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          id_allow_in,
   input  logic                          br_taken,
   input  logic [31:0]                   br_target,
   input  logic                          excp_flush,
   input  logic                          ertn_flush,
   input  logic [31:0]                   ex_entry,
   input  logic [31:0]                   er_entry,
   output logic                          inst_req,
   output logic [31:0]                   inst_addr,
   input  logic                          inst_addr_ok,
   input  logic                          inst_data_ok,
   input  logic [31:0]                   inst_rdata,
   output logic                          if_to_id_valid,
   output logic [31:0]                   if_to_id_pc,
   output logic [31:0]                   if_to_id_inst,
   output logic [$clog2(IBUF_DEPTH):0]   ibuf_count
);
   localparam int CW = $clog2(IBUF_DEPTH) + 1;
   localparam int AW = $clog2(IBUF_DEPTH);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;

   logic [31:0]   fpc_q, fpc_d;
   logic [OW-1:0] out_q, out_d, cancel_q, cancel_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] head_q, head_d, tail_q, tail_d;
   logic [PW-1:0] ph_q, ph_d, pt_q, pt_d;
   logic [31:0]   buf_pc_q [IBUF_DEPTH];
   logic [31:0]   buf_inst_q [IBUF_DEPTH];
   logic [31:0]   pend_q [MAX_OUTSTANDING];
   logic          redirect, accept, push, pop;
   logic [31:0]   target;

   always_comb begin
      redirect = excp_flush | ertn_flush | br_taken;
      target = excp_flush ? ex_entry : ertn_flush ? er_entry : br_target;
      inst_addr = fpc_q & 32'hffff_fffc;
      // credit counts only live (uncancelled) fetches so every response has a buffer slot
      inst_req = resetn && !redirect && int'(out_q) < MAX_OUTSTANDING &&
                 int'(out_q) - int'(cancel_q) + int'(cnt_q) < IBUF_DEPTH;
      accept = inst_req && inst_addr_ok;
      push = inst_data_ok && cancel_q == '0 && !redirect;
      if_to_id_valid = cnt_q != '0 && !redirect;
      pop = if_to_id_valid && id_allow_in;
      if_to_id_pc = if_to_id_valid ? buf_pc_q[head_q] : '0;
      if_to_id_inst = if_to_id_valid ? buf_inst_q[head_q] : '0;
      ibuf_count = cnt_q;
      fpc_d = redirect ? target & 32'hffff_fffc : accept ? fpc_q + 32'd4 : fpc_q;
      out_d = out_q + OW'(accept) - OW'(inst_data_ok);
      cancel_d = redirect ? out_q - OW'(inst_data_ok) :
                 (inst_data_ok && cancel_q != '0) ? cancel_q - 1'b1 : cancel_q;
      cnt_d = redirect ? '0 : cnt_q + CW'(push) - CW'(pop);
      head_d = redirect ? '0 : head_q + AW'(pop);
      tail_d = redirect ? '0 : tail_q + AW'(push);
      pt_d = !accept ? pt_q : pt_q == PW'(MAX_OUTSTANDING - 1) ? '0 : pt_q + 1'b1;
      ph_d = !inst_data_ok ? ph_q : ph_q == PW'(MAX_OUTSTANDING - 1) ? '0 : ph_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         fpc_q <= RESET_PC;
         out_q <= '0;
         cancel_q <= '0;
         cnt_q <= '0;
         head_q <= '0;
         tail_q <= '0;
         ph_q <= '0;
         pt_q <= '0;
      end else begin
         fpc_q <= fpc_d;
         out_q <= out_d;
         cancel_q <= cancel_d;
         cnt_q <= cnt_d;
         head_q <= head_d;
         tail_q <= tail_d;
         ph_q <= ph_d;
         pt_q <= pt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) pend_q[pt_q] <= inst_addr;
      if (push) begin
         buf_pc_q[tail_q] <= pend_q[ph_q];
         buf_inst_q[tail_q] <= inst_rdata;
      end
   end

   assert property (@(posedge clk) disable iff (!resetn)
      !(push && !pop && cnt_q == CW'(IBUF_DEPTH)));
   assert property (@(posedge clk) disable iff (!resetn)
      !(inst_data_ok && out_q == '0));
endmodule
